rocc_ctrl: RTL

ROCC_CTRL -- requirements
Module: rocc_ctrl

---
 rtl/ariane_pkg.sv | 13 +
 rtl/rocc_ctrl.sv | 122 ++++++++++++
 2 files changed

// File: rtl/ariane_pkg.sv
// Shared definitions for the RoCC accelerator controller in the execute stage.
package ariane_pkg;

  typedef enum logic [1:0] {
    ROCC_IDLE      = 2'd0,
    ROCC_CMD       = 2'd1,
    ROCC_WAIT_RESP = 2'd2,
    ROCC_DONE      = 2'd3
  } rocc_ctrl_state_e;

  localparam int unsigned ROCC_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/rocc_ctrl.sv
// RoCC controller: issues one instruction at a time to the accelerator and
// returns a single-cycle writeback (result or exception) to the scoreboard.
module rocc_ctrl
  import ariane_pkg::*;
#(
  parameter int unsigned TRANS_ID_BITS  = 3,
  parameter int unsigned TIMEOUT_CYCLES = ROCC_TIMEOUT_CYCLES
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     rocc_valid_i,
  output logic                     rocc_ready_o,
  input  logic [31:0]              rocc_instr_i,
  input  logic [63:0]              rs1_i,
  input  logic [63:0]              rs2_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  output logic                     cmd_valid_o,
  input  logic                     cmd_ready_i,
  output logic [31:0]              cmd_instr_o,
  output logic [63:0]              cmd_rs1_o,
  output logic [63:0]              cmd_rs2_o,
  input  logic                     resp_valid_i,
  output logic                     resp_ready_o,
  input  logic [4:0]               resp_rd_i,
  input  logic [63:0]              resp_data_i,
  output logic                     rocc_valid_o,
  output logic [TRANS_ID_BITS-1:0] rocc_trans_id_o,
  output logic [63:0]              rocc_result_o,
  output logic                     rocc_ex_valid_o,
  output logic                     busy_o,
  output rocc_ctrl_state_e         state_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  rocc_ctrl_state_e         state_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [31:0]              instr_q;
  logic [63:0]              rs1_q;
  logic [63:0]              rs2_q;
  logic [TRANS_ID_BITS-1:0] trans_id_q;
  logic [63:0]              result_q;
  logic                     ex_q;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; a valid source holds valid and payload stable until then, and
  // ready never depends on the partner's valid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ROCC_IDLE;
      cnt_q      <= '0;
      instr_q    <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      trans_id_q <= '0;
      result_q   <= '0;
      ex_q       <= 1'b0;
    end else begin
      case (state_q)
        ROCC_IDLE: begin
          if (rocc_valid_i && !flush_i) begin
            instr_q    <= rocc_instr_i;
            rs1_q      <= rs1_i;
            rs2_q      <= rs2_i;
            trans_id_q <= trans_id_i;
            result_q   <= '0;
            ex_q       <= 1'b0;
            state_q    <= ROCC_CMD;
          end
        end
        ROCC_CMD: begin
          // A flush racing the command handshake still counts the command as sent.
          if (flush_i) begin
            state_q <= ROCC_IDLE;
          end else if (cmd_ready_i) begin
            if (instr_q[14]) begin
              cnt_q   <= '0;
              state_q <= ROCC_WAIT_RESP;
            end else begin
              result_q <= '0;
              state_q  <= ROCC_DONE;
            end
          end
        end
        ROCC_WAIT_RESP: begin
          if (flush_i) begin
            state_q <= ROCC_IDLE;
          end else if (resp_valid_i) begin
            result_q <= resp_data_i;
            ex_q     <= (resp_rd_i != instr_q[11:7]);
            state_q  <= ROCC_DONE;
          end else if (cnt_q == CNT_LAST) begin
            result_q <= '0;
            ex_q     <= 1'b1;
            state_q  <= ROCC_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ROCC_DONE: state_q <= ROCC_IDLE;
        default:   state_q <= ROCC_IDLE;
      endcase
    end
  end

  assign rocc_ready_o    = (state_q == ROCC_IDLE) && !flush_i;
  assign cmd_valid_o     = (state_q == ROCC_CMD);
  assign cmd_instr_o     = instr_q;
  assign cmd_rs1_o       = rs1_q;
  assign cmd_rs2_o       = rs2_q;
  // Responses arriving while idle are stale and are drained silently.
  assign resp_ready_o    = (state_q == ROCC_IDLE) || (state_q == ROCC_WAIT_RESP);
  assign rocc_valid_o    = (state_q == ROCC_DONE) && !flush_i;
  assign rocc_trans_id_o = trans_id_q;
  assign rocc_result_o   = result_q;
  assign rocc_ex_valid_o = rocc_valid_o && ex_q;
  assign busy_o          = (state_q != ROCC_IDLE);
  assign state_o         = state_q;

endmodule
